// File: rtl/jtag_dtm_tap.sv
// JTAG TAP responder and RISC-V DTM (IDCODE/DTMCS/DMI/BYPASS), oversampled in the clk domain.
// Define JTAG_TCK_FILTER_EN to reject TCK pulses shorter than 3 clk (adds 2 clk edge latency).
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE    = 32'h1e200a6d,
    parameter int unsigned DMI_ABITS = 6,
    parameter int unsigned IR_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  jtag_TCK,
    input  logic                  jtag_TMS,
    input  logic                  jtag_TDI,
    output logic                  jtag_TDO,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [DMI_ABITS+33:0] dmi_req_data_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [33:0]           dmi_resp_data_i
);

    localparam int unsigned DMI_W = DMI_ABITS + 34;
    localparam logic [IR_BITS-1:0] INSTR_IDCODE = IR_BITS'(5'h01);
    localparam logic [IR_BITS-1:0] INSTR_DTMCS  = IR_BITS'(5'h10);
    localparam logic [IR_BITS-1:0] INSTR_DMI    = IR_BITS'(5'h11);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_e;

    tap_state_e state, state_next;

    logic [1:0] tck_sync, tms_sync, tdi_sync;
    logic       tck_lvl, tck_prev, rise, fall, tms, tdi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[0], jtag_TCK};
            tms_sync <= {tms_sync[0], jtag_TMS};
            tdi_sync <= {tdi_sync[0], jtag_TDI};
            tck_prev <= tck_lvl;
        end
    end

`ifdef JTAG_TCK_FILTER_EN
    logic [1:0] tck_hist;
    logic       tck_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tck_hist <= '0;
        else        tck_hist <= {tck_hist[0], tck_sync[1]};
    end

    // Accept a new level only once it has been seen on three consecutive clk edges.
    assign tck_stable = (tck_sync[1] == tck_hist[0]) && (tck_hist[0] == tck_hist[1]);
    assign tck_lvl    = tck_stable ? tck_sync[1] : tck_prev;
`else
    assign tck_lvl = tck_sync[1];
`endif

    assign rise = tck_lvl & ~tck_prev;
    assign fall = ~tck_lvl & tck_prev;
    assign tms  = tms_sync[1];
    assign tdi  = tdi_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TEST_LOGIC_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rise) begin
            unique case (state)
                TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_next = tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        state_next = tms ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       state_next = tms ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         state_next = tms ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         state_next = tms ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         state_next = tms ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         state_next = tms ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        state_next = tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_next = tms ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         state_next = tms ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         state_next = tms ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         state_next = tms ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         state_next = tms ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        state_next = tms ? SELECT_DR : RUN_TEST_IDLE;
                default:          state_next = TEST_LOGIC_RESET;
            endcase
        end
    end

    logic [IR_BITS-1:0]   ir, ir_sr;
    logic [DMI_W-1:0]     dr_sr;
    logic [DMI_ABITS-1:0] last_addr;
    logic [31:0]          resp_data, resp_data_n;
    logic [1:0]           dmistat, dmistat_rsp, dmi_op_cap;
    logic                 pending, resp_fire, outstanding_rsp;
    logic [31:0]          dtmcs_cap;

    assign dmi_resp_ready_o = pending;

    // A response landing in the same cycle as Capture-DR must be visible to that capture.
    always_comb begin
        resp_fire       = dmi_resp_valid_i & pending;
        resp_data_n     = resp_fire ? dmi_resp_data_i[33:2] : resp_data;
        dmistat_rsp     = (resp_fire && dmi_resp_data_i[1:0] != 2'd0) ? 2'd2 : dmistat;
        outstanding_rsp = dmi_req_valid_o | (pending & ~resp_fire);
        dmi_op_cap      = (dmistat_rsp != 2'd0) ? dmistat_rsp
                        : (outstanding_rsp ? 2'd3 : 2'd0);
        dtmcs_cap       = {14'b0, 1'b0, 1'b0, 1'b0, 3'd5, dmistat_rsp, 6'(DMI_ABITS), 4'd1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jtag_TDO        <= 1'b0;
            dmi_req_valid_o <= 1'b0;
            dmi_req_data_o  <= '0;
            pending         <= 1'b0;
            resp_data       <= '0;
            last_addr       <= '0;
            dmistat         <= '0;
            ir              <= INSTR_IDCODE;
            ir_sr           <= '0;
            dr_sr           <= '0;
        end else begin
            if (dmi_req_valid_o && dmi_req_ready_i) begin
                dmi_req_valid_o <= 1'b0;
                pending         <= 1'b1;
            end
            if (resp_fire) pending <= 1'b0;
            resp_data <= resp_data_n;
            dmistat   <= dmistat_rsp;

            if (state == TEST_LOGIC_RESET) ir <= INSTR_IDCODE;

            if (rise) begin
                unique case (state)
                    CAPTURE_IR: ir_sr <= IR_BITS'(1);
                    SHIFT_IR:   ir_sr <= {tdi, ir_sr[IR_BITS-1:1]};
                    UPDATE_IR:  ir    <= ir_sr;
                    CAPTURE_DR: begin
                        unique case (ir)
                            INSTR_IDCODE: dr_sr <= DMI_W'(IDCODE);
                            INSTR_DTMCS:  dr_sr <= DMI_W'(dtmcs_cap);
                            INSTR_DMI:    dr_sr <= {last_addr, resp_data_n, dmi_op_cap};
                            default:      dr_sr <= '0;
                        endcase
                    end
                    SHIFT_DR: begin
                        unique case (ir)
                            INSTR_DMI:                dr_sr <= {tdi, dr_sr[DMI_W-1:1]};
                            INSTR_IDCODE, INSTR_DTMCS: dr_sr <= DMI_W'({tdi, dr_sr[31:1]});
                            default:                  dr_sr <= DMI_W'(tdi);
                        endcase
                    end
                    UPDATE_DR: begin
                        if (ir == INSTR_DTMCS) begin
                            if (dr_sr[17]) begin
                                dmistat         <= '0;
                                dmi_req_valid_o <= 1'b0;
                                pending         <= 1'b0;
                            end else if (dr_sr[16]) begin
                                dmistat <= '0;
                            end
                        end else if (ir == INSTR_DMI &&
                                     (dr_sr[1:0] == 2'd1 || dr_sr[1:0] == 2'd2)) begin
                            if (outstanding_rsp) begin
                                dmistat <= 2'd3;
                            end else if (dmistat_rsp == 2'd0) begin
                                dmi_req_valid_o <= 1'b1;
                                dmi_req_data_o  <= dr_sr;
                                last_addr       <= dr_sr[DMI_W-1:34];
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (fall) begin
                if (state == SHIFT_IR)      jtag_TDO <= ir_sr[0];
                else if (state == SHIFT_DR) jtag_TDO <= dr_sr[0];
            end
        end
    end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Directed bench for jtag_dtm_tap: host-side JTAG bit-banging plus a hand-driven DM.
module tb_jtag_dtm_tap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
    logic        dmi_req_valid_o, dmi_req_ready_i;
    logic [39:0] dmi_req_data_o;
    logic        dmi_resp_valid_i, dmi_resp_ready_o;
    logic [33:0] dmi_resp_data_i;

    int n_pass  = 0;
    int n_total = 0;

    jtag_dtm_tap #(.IDCODE(32'h1e200a6d), .DMI_ABITS(6), .IR_BITS(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .jtag_TCK         (jtag_TCK),
        .jtag_TMS         (jtag_TMS),
        .jtag_TDI         (jtag_TDI),
        .jtag_TDO         (jtag_TDO),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One TCK period of 12 clk; TDO is sampled just before the rising edge.
    task automatic tck(input logic tms, input logic tdi, output logic tdo_s);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        #60;
        tdo_s    = jtag_TDO;
        jtag_TCK = 1'b1;
        #60;
        jtag_TCK = 1'b0;
    endtask

    task automatic scan_ir(input logic [4:0] val, output logic [4:0] cap);
        logic b;
        tck(1'b1, 1'b0, b);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, val[i], b);
            cap[i] = b;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input logic [39:0] val, input int n, output logic [39:0] cap);
        logic b;
        cap = '0;
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, val[i], b);
            cap[i] = b;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
    endtask

    task automatic dm_accept();
        @(negedge clk) dmi_req_ready_i = 1'b1;
        @(negedge clk) dmi_req_ready_i = 1'b0;
    endtask

    task automatic dm_respond(input logic [33:0] rsp);
        @(negedge clk) begin
            dmi_resp_valid_i = 1'b1;
            dmi_resp_data_i  = rsp;
        end
        @(negedge clk) dmi_resp_valid_i = 1'b0;
    endtask

    initial begin
        logic [4:0]  ir_cap;
        logic [39:0] dr_cap;
        logic        b;

        rst_n = 1'b0;
        jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0;
        dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_tdo",        64'(jtag_TDO), 64'd0);
        check("rst_req_valid",  64'(dmi_req_valid_o), 64'd0);
        check("rst_req_data",   64'(dmi_req_data_o), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Walk to Test-Logic-Reset, then Run-Test/Idle; read IDCODE.
        for (int i = 0; i < 8; i++) tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        scan_ir(5'h01, ir_cap);
        check("ir_capture", 64'(ir_cap), 64'h01);
        scan_dr(40'h0, 32, dr_cap);
        check("idcode", 64'(dr_cap[31:0]), 64'h1e200a6d);

        // DMI write-type request held until ready.
        scan_ir(5'h11, ir_cap);
        check("ir_capture_2", 64'(ir_cap), 64'h01);
        scan_dr({6'h10, 32'h0, 2'b10}, 40, dr_cap);
        check("req_valid", 64'(dmi_req_valid_o), 64'd1);
        check("req_data",  64'(dmi_req_data_o), 64'h40_0000_0002);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("req_valid_hold", 64'(dmi_req_valid_o), 64'd1);
            check("req_data_hold",  64'(dmi_req_data_o), 64'h40_0000_0002);
        end
        dm_accept();
        check("req_valid_drop", 64'(dmi_req_valid_o), 64'd0);
        check("resp_ready_on",  64'(dmi_resp_ready_o), 64'd1);
        dm_respond({32'h12345678, 2'b00});
        check("resp_ready_off", 64'(dmi_resp_ready_o), 64'd0);

        // DMI read and returned data on the following capture.
        scan_dr({6'h11, 32'h0, 2'b01}, 40, dr_cap);
        check("rd_req_data", 64'(dmi_req_data_o), 64'h44_0000_0001);
        dm_accept();
        dm_respond({32'h00400c82, 2'b00});
        scan_dr(40'h0, 40, dr_cap);
        check("rd_data", 64'(dr_cap[33:2]), 64'h00400c82);
        check("rd_op",   64'(dr_cap[1:0]), 64'd0);
        check("rd_addr", 64'(dr_cap[39:34]), 64'h11);
        check("nop_no_req", 64'(dmi_req_valid_o), 64'd0);

        // Overlapping read: busy is sticky until dmireset.
        scan_dr({6'h12, 32'h0, 2'b01}, 40, dr_cap);
        check("busy_first_req", 64'(dmi_req_data_o), 64'h48_0000_0001);
        scan_dr({6'h13, 32'h0, 2'b01}, 40, dr_cap);
        check("busy_cap_op3",  64'(dr_cap[1:0]), 64'd3);
        check("busy_req_kept", 64'(dmi_req_data_o), 64'h48_0000_0001);
        check("busy_valid",    64'(dmi_req_valid_o), 64'd1);
        dm_accept();
        dm_respond({32'hcafef00d, 2'b00});
        scan_dr(40'h0, 40, dr_cap);
        check("busy_sticky", 64'(dr_cap[1:0]), 64'd3);
        scan_ir(5'h10, ir_cap);
        scan_dr(40'h0001_0000, 32, dr_cap);
        check("dtmcs_cap", 64'(dr_cap[31:0]), 64'h0000_5c61);
        scan_ir(5'h11, ir_cap);
        scan_dr(40'h0, 40, dr_cap);
        check("cleared_op",   64'(dr_cap[1:0]), 64'd0);
        check("cleared_data", 64'(dr_cap[33:2]), 64'hcafef00d);
        check("cleared_addr", 64'(dr_cap[39:34]), 64'h12);

        // BYPASS: one-bit delay with a captured 0 in front.
        scan_ir(5'h1f, ir_cap);
        scan_dr(40'h0a5, 9, dr_cap);
        check("bypass", 64'(dr_cap[8:0]), 64'h14a);

        // A 2-clk TCK glitch with TMS=1 from Run-Test/Idle.
        scan_ir(5'h01, ir_cap);
        @(negedge clk);
        jtag_TMS = 1'b1;
        #60 jtag_TCK = 1'b1;
        #20 jtag_TCK = 1'b0;
        #60;
        tck(1'b1, 1'b1, b);
        tck(1'b0, 1'b1, b);
        tck(1'b0, 1'b1, b);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, 1'b1, b);
            ir_cap[i] = b;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
`ifdef JTAG_TCK_FILTER_EN
        check("glitch_filtered", 64'(ir_cap), 64'h0d);
`else
        check("glitch_seen", 64'(ir_cap), 64'h01);
`endif

        // Asynchronous reset in the middle of a pending request.
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        scan_ir(5'h11, ir_cap);
        scan_dr({6'h05, 32'h0, 2'b01}, 40, dr_cap);
        check("pre_rst_valid", 64'(dmi_req_valid_o), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(dmi_req_valid_o), 64'd0);
        check("mid_rst_data",  64'(dmi_req_data_o), 64'd0);
        check("mid_rst_tdo",   64'(jtag_TDO), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jtag_dtm_tap.md
Name: jtag_dtm_tap

Overview:
- JTAG TAP responder and Debug Transport Module (DTM) running entirely in the `clk` domain.
- The TCK/TMS/TDI pins are oversampled, the IEEE 1149.1 16-state TAP FSM is tracked, and IDCODE / DTMCS / DMI / BYPASS data registers are served.
- Completed DMI scans are converted into 40-bit requests toward the debug module; the debug module's responses are returned on later scans.
- Sits between the SoC JTAG pins and the DM, as the target end of the host-driven IR/DR scan sequence.

Parameters:
- IDCODE, 32'h1e200a6d, value captured in the IDCODE DR.
- DMI_ABITS, 6, DMI address width.
- IR_BITS, 5, instruction register length.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- jtag_TCK  in  1  JTAG clock, asynchronous; its period is ≥ 8 clk.
- jtag_TMS  in  1  JTAG mode select.
- jtag_TDI  in  1  JTAG data in.
- jtag_TDO  out  1  JTAG data out.
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  DM accepts the request.
- dmi_req_data_o  out  40  {addr[5:0], data[31:0], op[1:0]}.
- dmi_resp_valid_i  in  1  DM response valid.
- dmi_resp_ready_o  out  1  DTM accepts the response.
- dmi_resp_data_i  in  34  {data[31:0], resp[1:0]}.

Behaviour:
- Synchronisation and edge detect:
  - TCK/TMS/TDI each pass through 2-flop synchronisers.
  - Rise = sync TCK 0→1; fall = 1→0, both one clk after the synchronised change.
  - All TAP actions occur in the clk cycle a rise or fall is detected.
- TAP FSM: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, plus the IR equivalents.
  - Transitions follow the standard TMS table on each rise.
  - Reset state is TEST_LOGIC_RESET.
  - Five rises with TMS=1 reach TEST_LOGIC_RESET from any state.
- IR:
  - IR = 5'h01 (IDCODE) in TEST_LOGIC_RESET.
  - Capture-IR loads 5'b00001; Shift-IR shifts LSB-first, TDI into the MSB.
  - Update-IR copies the shift register into IR.
  - Decoded instructions: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (40b). Any other value selects BYPASS (1b, captures 0).
- DR shifting:
  - Capture-DR loads the selected register into a 40-bit shift register.
  - Shift-DR on rise: sr = {TDI, sr[N-1:1]}, where N is the selected length.
- TDO:
  - Updated on fall: in Shift-IR/Shift-DR it equals sr[0]; otherwise it holds its last value.
  - Reset value 0.
- DTMCS capture value: {14'b0, dmihardreset 0, dmireset 0, 1'b0, idle 3'd5, dmistat[1:0], abits 6'd6, version 4'd1}.
- DTMCS Update-DR:
  - bit16 (dmireset) clears the sticky dmistat.
  - bit17 (dmihardreset) clears dmistat and drops any pending req/resp.
- DMI capture value: {last_addr, last_resp_data[31:0], op}, where op = dmistat if nonzero, else 2'd3 while a request is outstanding, else 2'd0.
- DMI Update-DR with op=1 (read) or op=2 (write):
  - If dmistat==0 and idle: latch sr into dmi_req_data_o, assert dmi_req_valid_o, and record the address.
  - If a request is outstanding: set dmistat=3 (busy, sticky) and issue nothing.
  - op=0 or op=3: no request.
- Request handshake:
  - dmi_req_valid_o is held with stable data until dmi_req_ready_i is high in the same cycle, then deasserts next cycle.
  - After acceptance the request stays outstanding until the response.
- Response handshake:
  - dmi_resp_ready_o = 1 while outstanding.
  - On dmi_resp_valid_i: latch the response data and clear outstanding.
  - A nonzero resp code sets dmistat=2.
  - A response arriving in the same cycle as Capture-DR is latched first, so the capture sees it.
- Reset values: jtag_TDO=0, dmi_req_valid_o=0, dmi_req_data_o=0, dmi_resp_ready_o=0, dmistat=0, IR=5'h01.
- TEST_LOGIC_RESET clears IR only; it does not cancel an outstanding DMI access.
- rst_n asserted mid-scan or mid-request returns everything to the reset values immediately.

Optional Feature:
- Macro: JTAG_TCK_FILTER_EN.
- When defined: the synchronised TCK must hold its new level for 2 further clk cycles before a rise/fall is recognised. Pulses shorter than 3 clk are ignored, and edge latency grows by 2 clk.
- When undefined: edges are recognised directly from the 2-flop synchroniser output.

Test Plan:
- Reset, then 8 TCK with TMS=1, then IR scan of 5'h01 and a 32-bit DR scan -> TDO stream equals 32'h1e200a6d LSB-first; the IR capture shifts out 5'b00001.
- IR=5'h11, DR scan {6'h10, 32'h0, 2'b10}, Update-DR -> dmi_req_valid_o=1 with dmi_req_data_o=40'h4000000002. Hold dmi_req_ready_i=0 for 5 clk -> valid and data stable; pulse ready -> valid drops next clk.
- DMI read {6'h11, 32'h0, 2'b01}; DM returns {32'h00400c82, 2'b00}; next DMI scan with op=0 -> shifted-out bits [33:2]=32'h00400c82, [1:0]=0, [39:34]=6'h11.
- Second DMI read issued while the first is outstanding -> no new request; subsequent captures show op=3. DTMCS write with bit16=1 -> next DMI capture op=0 once the response has arrived.
- IR=5'h1f, shift 8'hA5 through DR -> TDO returns 0 then 8'hA5 delayed by one TCK.
- With JTAG_TCK_FILTER_EN: a 2-clk glitch on TCK -> TAP state unchanged; without the macro -> TAP state advances.
